// File: rtl/freq_meter_pkg.sv
// Shared definitions for the four-channel gated frequency meter.
// Build option: FREQ_METER_BOTH_EDGES_EN (see edge_sync_det) changes what counts as an edge.
package freq_meter_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/freq_meter_4ch_edge_sync_det.sv
// Per-channel synchroniser, history flop and single-cycle edge pulse.
// Build option: FREQ_METER_BOTH_EDGES_EN counts falling as well as rising edges.
module edge_sync_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

`ifdef FREQ_METER_BOTH_EDGES_EN
    assign pulse = sync_reg[SYNC_STAGES-1] ^ hist_reg;
`else
    assign pulse = sync_reg[SYNC_STAGES-1] & ~hist_reg;
`endif

endmodule

// File: rtl/freq_meter_4ch.sv
// Four-channel gated edge counter with per-window result latching and readback mux.
// Build option: FREQ_METER_BOTH_EDGES_EN (passed through to edge_sync_det).
module freq_meter_4ch
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [3:0]       sig_in,
    input  logic [1:0]       rd_sel,
    output logic [CNT_W-1:0] rd_count,
    output logic [3:0]       ovf,
    output logic             done,
    output logic             busy
);

    localparam int               GATE_W   = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state_reg, state_next;
    logic [GATE_W-1:0] gate_cnt_reg, gate_cnt_next;
    logic              done_reg;

    logic cnt_clear;
    logic cnt_run;
    logic cnt_reload;
    logic latch_en;

    logic [NUM_CH-1:0] edge_pulse;
    logic [CNT_W-1:0]  result_arr [NUM_CH];
    logic [NUM_CH-1:0] ovf_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            gate_cnt_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gate_cnt_reg <= gate_cnt_next;
            done_reg     <= latch_en;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gate_cnt_next = gate_cnt_reg;
        cnt_clear     = 1'b0;
        cnt_run       = 1'b0;
        cnt_reload    = 1'b0;
        latch_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_clear = 1'b1;
                if (enable) begin
                    state_next    = GATE;
                    gate_cnt_next = '0;
                end
            end
            GATE: begin
                cnt_run       = 1'b1;
                gate_cnt_next = gate_cnt_reg + 1'b1;
                if (gate_cnt_reg == GATE_LAST) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                // The latch cycle's own edge seeds the next window so nothing is lost.
                latch_en = 1'b1;
                if (enable) begin
                    state_next    = GATE;
                    gate_cnt_next = '0;
                    cnt_reload    = 1'b1;
                end else begin
                    state_next = IDLE;
                    cnt_clear  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] result_reg;
            logic             sat_reg;
            logic             ovf_reg;

            edge_sync_det #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_det (
                .clk   (clk),
                .rst_n (rst_n),
                .sig   (sig_in[gi]),
                .pulse (edge_pulse[gi])
            );

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg    <= '0;
                    result_reg <= '0;
                    sat_reg    <= 1'b0;
                    ovf_reg    <= 1'b0;
                end else begin
                    if (latch_en) begin
                        result_reg <= cnt_reg;
                        ovf_reg    <= sat_reg;
                    end
                    if (cnt_clear) begin
                        cnt_reg <= '0;
                        sat_reg <= 1'b0;
                    end else if (cnt_reload) begin
                        cnt_reg <= CNT_W'(edge_pulse[gi]);
                        sat_reg <= 1'b0;
                    end else if (cnt_run && edge_pulse[gi]) begin
                        // Saturate rather than wrap; remember that an edge was dropped.
                        if (cnt_reg == CNT_MAX) begin
                            sat_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
            end

            assign result_arr[gi] = result_reg;
            assign ovf_bits[gi]   = ovf_reg;
        end
    endgenerate

    assign rd_count = result_arr[rd_sel];
    assign ovf      = ovf_bits;
    assign done     = done_reg;
    assign busy     = (state_reg == GATE);

endmodule
